alu_ex_mem_stage: RTL

Registered EX/MEM boundary stage directly downstream of the 16-bit ALU.
- Captures the ALU result and carry-out, and derives zero, negative, carry and overflow flags.
- Forwards result, flags and the writeback tag to the memory stage through a valid/ready handshake.
- Holds a 2-entry skid buffer so the upstream ALU can run at full throughput while the memory stage back-pressures.

---
 rtl/alu_ex_mem_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_ex_mem_stage.sv
// EX/MEM boundary stage: registers the ALU result, derives flags at capture and
// forwards them downstream through a two-entry (main + skid) valid/ready buffer.
module alu_ex_mem_stage #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter logic [2:0]  ADD_OP = 3'b010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             bnegate,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] dest,
  input  logic             reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_overflow,
  output logic [TAG_W-1:0] out_dest,
  output logic             out_reg_write,
  output logic [15:0]      stall_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             overflow;
    logic [TAG_W-1:0] dest;
    logic             reg_write;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e      state_q;
  entry_t      main_q;
  entry_t      skid_q;
  entry_t      in_entry;
  logic [15:0] stall_q;
  logic        accept;
  logic        emit;
  logic        is_add;
  logic        b_eff;
  logic        res_msb;

  assign is_add  = (op == ADD_OP);
  assign b_eff   = b_msb ^ bnegate;
  assign res_msb = alu_result[WIDTH-1];

  always_comb begin
    in_entry           = '0;
    in_entry.result    = alu_result;
    in_entry.zero      = ~|alu_result;
    in_entry.neg       = res_msb;
    in_entry.carry     = is_add & alu_cout;
    // Signed overflow: result sign differs from both effective operand signs.
    in_entry.overflow  = is_add & (a_msb ^ res_msb) & (b_eff ^ res_msb);
    in_entry.dest      = dest;
    in_entry.reg_write = reg_write;
  end

  // Ready and valid decode purely from registered state.
  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (flush) begin
        state_q <= StEmpty;
      end else begin
        case (state_q)
          StEmpty: begin
            if (accept) begin
              main_q  <= in_entry;
              state_q <= StOne;
            end
          end
          StOne: begin
            if (accept && emit) begin
              main_q <= in_entry;
            end else if (accept) begin
              skid_q  <= in_entry;
              state_q <= StTwo;
            end else if (emit) begin
              state_q <= StEmpty;
            end
          end
          StTwo: begin
            if (emit) begin
              main_q  <= skid_q;
              state_q <= StOne;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

  assign out_result    = main_q.result;
  assign out_zero      = main_q.zero;
  assign out_neg       = main_q.neg;
  assign out_carry     = main_q.carry;
  assign out_overflow  = main_q.overflow;
  assign out_dest      = main_q.dest;
  assign out_reg_write = main_q.reg_write;
  assign stall_cnt     = stall_q;

endmodule
